oled_source_arbiter: RTL

Frame-synchronous arbiter that shares the 96x64 OLED pixel stream among four pixel sources: soundbar, volume bar, menu and test pattern. It grants one requester at a time and changes grants only on frame boundaries, so a frame never mixes two sources. It also owns the 2-bit colour-scheme setting `R` that feeds every source's colour selector, and applies theme changes on frame boundaries too. It sits between the pixel-generator blocks and the OLED driver's `pixel_data` input.

---
 rtl/oled_source_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/oled_source_arbiter.sv
// Frame-synchronous arbiter sharing the OLED pixel stream among four sources.
// Grants change only on frame boundaries. Rotation is round-robin, with a minimum
// hold time while other sources are waiting. The colour scheme R is also applied
// only on frame boundaries.
module oled_source_arbiter #(
  parameter int unsigned HOLD_FRAMES = 8,
  parameter logic [15:0] BG_COLOUR   = 16'h0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        frame_begin,
  input  logic [3:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  input  logic [15:0] data3,
  input  logic        theme_next,
  output logic [3:0]  grant,
  output logic [1:0]  R,
  output logic [15:0] pixel_data,
  output logic        switch_pulse
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cur_q, cur_d;
  logic [7:0]  hold_q, hold_d;
  logic [1:0]  rr_q, rr_d;
  logic [3:0]  grant_q, grant_d;
  logic        switch_q, switch_d;
  logic [15:0] pix_q, pix_d;
  logic [1:0]  pend_q, pend_d;
  logic [1:0]  r_q, r_d;

  logic [3:0]  others;
  logic [7:0]  hold_limit;

  assign hold_limit = 8'(HOLD_FRAMES - 1);
  assign others     = req & ~(4'b0001 << cur_q);

  // Return the first set bit of v, searching upward from start and wrapping mod 4.
  function automatic logic [1:0] pick_first(input logic [3:0] v, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    res   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && v[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // State register: arbitration state, theme state and registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      hold_q   <= '0;
      rr_q     <= '0;
      grant_q  <= '0;
      switch_q <= 1'b0;
      pix_q    <= '0;
      pend_q   <= '0;
      r_q      <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      hold_q   <= hold_d;
      rr_q     <= rr_d;
      grant_q  <= grant_d;
      switch_q <= switch_d;
      pix_q    <= pix_d;
      pend_q   <= pend_d;
      r_q      <= r_d;
    end
  end

  // Next-state logic: arbitration decisions happen only in frame_begin cycles.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    hold_d  = hold_q;
    rr_d    = rr_q;
    if (frame_begin) begin
      unique case (state_q)
        IDLE: begin
          if (req != '0) begin
            state_d = ACTIVE;
            cur_d   = pick_first(req, rr_q);
            hold_d  = '0;
            rr_d    = cur_d + 2'd1;
          end
        end
        ACTIVE: begin
          if (!req[cur_q]) begin
            if (others != '0) begin
              cur_d  = pick_first(others, rr_q);
              hold_d = '0;
              rr_d   = cur_d + 2'd1;
            end else begin
              state_d = IDLE;
            end
          end else if ((others != '0) && (hold_q >= hold_limit)) begin
            cur_d  = pick_first(others, rr_q);
            hold_d = '0;
            rr_d   = cur_d + 2'd1;
          end else if (hold_q != 8'hFF) begin
            hold_d = hold_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic: the one-hot grant, the change pulse, and a pixel mux driven by the registered owner.
  always_comb begin
    grant_d  = (state_d == ACTIVE) ? (4'b0001 << cur_d) : '0;
    switch_d = (grant_d != grant_q);
    pix_d    = BG_COLOUR;
    if (state_q == ACTIVE) begin
      unique case (cur_q)
        2'd0: pix_d = data0;
        2'd1: pix_d = data1;
        2'd2: pix_d = data2;
        2'd3: pix_d = data3;
        default: pix_d = BG_COLOUR;
      endcase
    end
  end

  // Theme logic: pend follows each theme_next pulse, and R takes pend (including a coincident pulse) at a frame boundary.
  always_comb begin
    pend_d = pend_q + {1'b0, theme_next};
    r_d    = frame_begin ? pend_d : r_q;
  end

  assign grant        = grant_q;
  assign switch_pulse = switch_q;
  assign pixel_data   = pix_q;
  assign R            = r_q;

endmodule
